// File: rtl/line_dispatch_queue.sv
// Line-segment dispatch queue: buffers decoder segments in a FIFO and launches
// them one at a time into the rasterizer, counting completed lines.
module line_dispatch_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lineValid,
    output logic          lineReady,
    input  logic [10:0]   inStartX,
    input  logic [10:0]   inStartY,
    input  logic [10:0]   inEndX,
    input  logic [10:0]   inEndY,
    input  logic [3:0]    inColor,
    input  logic          flush,
    input  logic          rastReady,
    input  logic          done,
    output logic [10:0]   startX,
    output logic [10:0]   startY,
    output logic [10:0]   endX,
    output logic [10:0]   endY,
    output logic [3:0]    lineColor,
    output logic          readyIn,
    output logic [CW-1:0] count,
    output logic [15:0]   linesDone,
    output logic          idle
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign lineReady = !rst && !full;
    // flush wins over a simultaneous push
    assign push      = lineValid && lineReady && !flush;
    assign readyIn   = (state_q == S_LAUNCH);
    assign idle      = empty && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && rastReady && !flush) begin
                    pop     = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage is intentionally not reset; only pointers and count are.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {inStartX, inStartY, inEndX, inEndY, inColor};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            startX    <= '0;
            startY    <= '0;
            endX      <= '0;
            endY      <= '0;
            lineColor <= '0;
            linesDone <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end
            if (pop) {startX, startY, endX, endY, lineColor} <= mem[rd_ptr];
            if (state_q == S_WAIT && done) linesDone <= linesDone + 16'd1;
        end
    end

endmodule
